// File: rtl/sfp_dis_prio_ctrl.sv
// SFP TX-disable controller driven by the backplane priority-encode lines:
// synchronize, debounce, descramble, pick this slot's line and sequence tx disable.
module sfp_dis_prio_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 1000,
    parameter int HOLDOFF_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sfp_dis_od,
    input  logic [2:0] bp_slot_addr,
    input  logic [1:0] prio_enc_descramble,
    input  logic       force_dis,
    output logic       sfp_tx_dis,
    output logic [1:0] ctrl_state,
    output logic [7:0] lines_descrambled,
    output logic [7:0] disable_events
);

    typedef enum logic [1:0] {
        SETTLE   = 2'b00,
        DISABLED = 2'b01,
        ENABLED  = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLDOFF_CYCLES);

    logic [7:0]       sync_q [SYNC_STAGES];
    logic [7:0]       deb;
    logic [CNT_W-1:0] deb_cnt [8];
    logic [2:0]       slot_q;
    logic [1:0]       mode_q;
    logic             cfg_valid;
    logic             cfg_change;
    logic             sel;
    state_t           state;
    logic [CNT_W-1:0] fsm_cnt;

    // Idle level of the open-drain lines is high, so the chains reset to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'hFF;
        end else begin
            sync_q[0] <= sfp_dis_od;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= 8'hFF;
            for (int b = 0; b < 8; b++) deb_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (sync_q[SYNC_STAGES-1][b] != deb[b]) begin
                    if (deb_cnt[b] == DEB_LAST) begin
                        deb[b]     <= sync_q[SYNC_STAGES-1][b];
                        deb_cnt[b] <= '0;
                    end else begin
                        deb_cnt[b] <= deb_cnt[b] + 1'b1;
                    end
                end else begin
                    deb_cnt[b] <= '0;
                end
            end
        end
    end

    always_comb begin
        lines_descrambled = {deb[6], deb[7], 6'h3F};
        case (prio_enc_descramble)
            2'b00:   lines_descrambled[5:0] = {deb[2], deb[3], deb[1], deb[0], deb[5], deb[4]};
            2'b01:   lines_descrambled[5:0] = {deb[5], deb[4], deb[2], deb[3], deb[0], deb[1]};
            2'b10:   lines_descrambled[5:0] = deb[5:0];
            default: lines_descrambled[5:0] = 6'h3F;
        endcase
    end

    assign sel = lines_descrambled[bp_slot_addr];

    // cfg_valid masks the very first clock, when the shadows are only being loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q    <= '0;
            mode_q    <= '0;
            cfg_valid <= 1'b0;
        end else begin
            slot_q    <= bp_slot_addr;
            mode_q    <= prio_enc_descramble;
            cfg_valid <= 1'b1;
        end
    end

    assign cfg_change = cfg_valid &&
                        ((bp_slot_addr != slot_q) || (prio_enc_descramble != mode_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= SETTLE;
            fsm_cnt        <= '0;
            sfp_tx_dis     <= 1'b1;
            disable_events <= '0;
        end else if (cfg_change) begin
            state      <= SETTLE;
            fsm_cnt    <= '0;
            sfp_tx_dis <= 1'b1;
            if (state == ENABLED && disable_events != 8'hFF)
                disable_events <= disable_events + 8'd1;
        end else begin
            case (state)
                SETTLE: begin
                    sfp_tx_dis <= 1'b1;
                    if (fsm_cnt == DEB_LAST) begin
                        state   <= DISABLED;
                        fsm_cnt <= '0;
                    end else begin
                        fsm_cnt <= fsm_cnt + 1'b1;
                    end
                end
                DISABLED: begin
                    if (fsm_cnt == HOLD_MAX && !sel && !force_dis) begin
                        state      <= ENABLED;
                        sfp_tx_dis <= 1'b0;
                    end else begin
                        sfp_tx_dis <= 1'b1;
                        if (fsm_cnt != HOLD_MAX) fsm_cnt <= fsm_cnt + 1'b1;
                    end
                end
                ENABLED: begin
                    if (sel || force_dis) begin
                        state      <= DISABLED;
                        fsm_cnt    <= '0;
                        sfp_tx_dis <= 1'b1;
                        if (disable_events != 8'hFF)
                            disable_events <= disable_events + 8'd1;
                    end else begin
                        sfp_tx_dis <= 1'b0;
                    end
                end
                default: begin
                    state      <= SETTLE;
                    fsm_cnt    <= '0;
                    sfp_tx_dis <= 1'b1;
                end
            endcase
        end
    end

    assign ctrl_state = state;

endmodule

// File: doc/sfp_dis_prio_ctrl.md
Name: sfp_dis_prio_ctrl

Overview:
Controller for the backplane priority-encode SFP-disable lines. It samples the eight open-drain lines, synchronizes and debounces them, and applies the register-selected descramble mapping for the backplane/PTC version. It then picks the line for this board's slot and runs a state machine that sequences the local SFP TX-disable with settle and hold-off timing. It sits between the backplane pins and the SFP TX_DISABLE driver, configured from the register block.

Parameters:
SYNC_STAGES, 2, synchronizer flops per input line (minimum 2)
DEB_CYCLES, 1000, consecutive stable cycles needed before a debounced bit changes (minimum 1)
HOLDOFF_CYCLES, 4096, minimum cycles in DISABLED before re-enable is allowed (minimum 1)
CNT_W, 16, width of the debounce and hold-off counters; must hold DEB_CYCLES and HOLDOFF_CYCLES

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sfp_dis_od  in  8  raw backplane priority-encode lines, asynchronous; 1 = disable/idle (pulled high)
bp_slot_addr  in  3  backplane slot address, quasi-static
prio_enc_descramble  in  2  descramble mode register
force_dis  in  1  software force-disable, synchronous to clk
sfp_tx_dis  out  1  registered SFP TX disable; 1 = disabled
ctrl_state  out  2  00 SETTLE, 01 DISABLED, 10 ENABLED
lines_descrambled  out  8  debounced, descrambled lines
disable_events  out  8  saturating count of ENABLED->DISABLED transitions

Behaviour:
- Reset (async assert, sync release):
  - sync chains and debounced bits = 8'hFF; counters = 0; disable_events = 0.
  - ctrl_state = SETTLE; sfp_tx_dis = 1.
  - Config shadow registers load the current bp_slot_addr and prio_enc_descramble on the first clock after release.
- Synchronizer: SYNC_STAGES flops per bit, no reset-dependent glitch; sync chains reset to 1.
- Debounce, per bit, applied before descramble:
  - Each cycle sync != deb: counter increments. Each cycle sync == deb: counter clears.
  - When counter == DEB_CYCLES-1 and sync still differs: deb takes sync and counter clears.
  - Result: a clean edge appears on deb exactly DEB_CYCLES cycles after it appears at the sync output. Glitches shorter than DEB_CYCLES are ignored.
- Descramble, combinational from deb (d = lines_descrambled):
  - Mode 00: d[0]=deb[4], d[1]=deb[5], d[2]=deb[0], d[3]=deb[1], d[4]=deb[3], d[5]=deb[2].
  - Mode 01: d[0]=deb[1], d[1]=deb[0], d[2]=deb[3], d[3]=deb[2], d[4]=deb[4], d[5]=deb[5].
  - Mode 10: d[i]=deb[i] for i in 0..5.
  - Mode 11: d[5:0]=6'h3F (all disabled).
  - All modes: d[6]=deb[7], d[7]=deb[6].
- Selected line: sel = d[bp_slot_addr].
- cfg_change: asserted when bp_slot_addr or prio_enc_descramble differs from its shadow register. The shadow updates on the same cycle.
- FSM, one transition per clock; sfp_tx_dis registered from the next state:
  - SETTLE: tx_dis=1; counter counts to DEB_CYCLES-1, then goes to DISABLED with the hold-off counter at 0.
  - DISABLED: tx_dis=1; hold-off counter increments and saturates at HOLDOFF_CYCLES. Goes to ENABLED when hold-off has reached HOLDOFF_CYCLES, sel==0 and force_dis==0.
  - ENABLED: tx_dis=0. Goes to DISABLED on sel==1 or force_dis==1; hold-off clears and disable_events increments, saturating at 255.
  - cfg_change in any state: go to SETTLE with the counter cleared. This has priority over all other transitions. A cfg_change in ENABLED also counts as a disable event.
- Latency:
  - Raw line fall to sfp_tx_dis fall, with hold-off already expired: SYNC_STAGES + DEB_CYCLES + 1 cycles.
  - force_dis rise to sfp_tx_dis rise: 1 cycle.
- Simultaneous events:
  - sel returns to 1 on the same cycle hold-off expires: stay in DISABLED.
  - force_dis and cfg_change together: go to SETTLE.
- Reset mid-operation: sfp_tx_dis goes to 1 immediately (asynchronously); all state is lost.

Test Plan:
Each scenario uses SYNC_STAGES=2, DEB_CYCLES=4, HOLDOFF_CYCLES=16.
1. Mode 10, slot 3. Release reset with lines 8'hFF, then drive bit3 low at cycle 30. Required: SETTLE for 4 cycles, then DISABLED. sfp_tx_dis falls 7 cycles after the bit3 edge (hold-off already expired). ctrl_state=10.
2. Mode 00, slot 1, drive only raw bit5 low. Required: lines_descrambled=8'hFD and sfp_tx_dis falls. Then mode 01 with raw bit0 low: the same result after SETTLE.
3. ENABLED, pulse raw selected line high for 3 cycles. Required: no change to sfp_tx_dis. A 4-cycle pulse (then low again) gives sfp_tx_dis=1 for at least 16 cycles of hold-off, and disable_events increments by 1.
4. ENABLED, set mode 11. Required: ctrl_state=SETTLE next cycle and sfp_tx_dis=1. The block stays disabled, with d[5:0]=6'h3F.
5. ENABLED, assert force_dis. Required: sfp_tx_dis=1 next cycle. Toggle 300 times: disable_events saturates at 255.
6. ENABLED, assert rst_n low mid-cycle. Required: sfp_tx_dis=1 immediately with no clock, and disable_events=0.
